// File: rtl/edge_to_level_gen.sv
// rtl/edge_to_level_gen.sv - rebuilds a level from rise/fall request pulses with min high/low hold times
module edge_to_level_gen #(
  parameter int MIN_HIGH = 4,
  parameter int MIN_LOW  = 4,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rise_req,
  input  logic        fall_req,
  output logic        sig_out,
  output logic        busy,
  output logic        pend,
  output logic        drop_err,
  output logic [15:0] edge_cnt
);

  typedef enum logic [1:0] {
    LOW_READY  = 2'd0,
    HIGH_HOLD  = 2'd1,
    HIGH_READY = 2'd2,
    LOW_HOLD   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(MIN_HIGH - 1);
  localparam logic [CNT_W-1:0] LOW_LOAD  = CNT_W'(MIN_LOW - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             both_req;
  logic             rise_ok;
  logic             fall_ok;
  logic             pend_hi;
  logic             pend_lo;

  assign both_req = rise_req & fall_req;
  assign rise_ok  = rise_req & ~fall_req;
  assign fall_ok  = fall_req & ~rise_req;

  // Pending flag as it stands after this cycle's request, so a request
  // arriving on the last hold cycle still takes effect at the hold boundary.
  always_comb begin
    pend_hi = fall_ok | (pend & ~rise_ok);
    pend_lo = rise_ok | (pend & ~fall_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOW_READY;
      cnt      <= '0;
      sig_out  <= 1'b0;
      busy     <= 1'b0;
      pend     <= 1'b0;
      drop_err <= 1'b0;
      edge_cnt <= 16'd0;
    end else begin
      drop_err <= both_req;
      case (state)
        LOW_READY: begin
          if (rise_ok) begin
            state    <= HIGH_HOLD;
            sig_out  <= 1'b1;
            busy     <= 1'b1;
            cnt      <= HIGH_LOAD;
            edge_cnt <= edge_cnt + 16'd1;
          end
        end
        HIGH_HOLD: begin
          if (cnt == '0) begin
            pend <= 1'b0;
            if (pend_hi) begin
              state    <= LOW_HOLD;
              sig_out  <= 1'b0;
              cnt      <= LOW_LOAD;
              edge_cnt <= edge_cnt + 16'd1;
            end else begin
              state <= HIGH_READY;
              busy  <= 1'b0;
            end
          end else begin
            cnt  <= cnt - CNT_W'(1);
            pend <= pend_hi;
          end
        end
        HIGH_READY: begin
          if (fall_ok) begin
            state    <= LOW_HOLD;
            sig_out  <= 1'b0;
            busy     <= 1'b1;
            cnt      <= LOW_LOAD;
            edge_cnt <= edge_cnt + 16'd1;
          end
        end
        LOW_HOLD: begin
          if (cnt == '0) begin
            pend <= 1'b0;
            if (pend_lo) begin
              state    <= HIGH_HOLD;
              sig_out  <= 1'b1;
              cnt      <= HIGH_LOAD;
              edge_cnt <= edge_cnt + 16'd1;
            end else begin
              state <= LOW_READY;
              busy  <= 1'b0;
            end
          end else begin
            cnt  <= cnt - CNT_W'(1);
            pend <= pend_lo;
          end
        end
        default: begin
          state   <= LOW_READY;
          sig_out <= 1'b0;
          busy    <= 1'b0;
          pend    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_edge_to_level_gen.sv
// tb/tb_edge_to_level_gen.sv - self-checking bench for edge_to_level_gen
module tb_edge_to_level_gen;

  localparam int MH = 4;
  localparam int ML = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rise_req = 1'b0;
  logic        fall_req = 1'b0;
  logic        sig_out, busy, pend, drop_err;
  logic [15:0] edge_cnt;

  logic        f_rise = 1'b0;
  logic        f_fall = 1'b0;
  logic        f_sig, f_busy, f_pend, f_drop;
  logic [15:0] f_edge;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: level plus the cycle at which that level began.
  int m_level, m_t, m_cyc, m_edges;
  bit m_queued, m_drop;

  edge_to_level_gen #(.MIN_HIGH(MH), .MIN_LOW(ML), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .rise_req(rise_req), .fall_req(fall_req),
    .sig_out(sig_out), .busy(busy), .pend(pend), .drop_err(drop_err),
    .edge_cnt(edge_cnt)
  );

  edge_to_level_gen #(.MIN_HIGH(1), .MIN_LOW(1), .CNT_W(4)) u_fast (
    .clk(clk), .rst(rst), .rise_req(f_rise), .fall_req(f_fall),
    .sig_out(f_sig), .busy(f_busy), .pend(f_pend), .drop_err(f_drop),
    .edge_cnt(f_edge)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_level  = 0;
    m_t      = -1000;
    m_cyc    = 0;
    m_edges  = 0;
    m_queued = 1'b0;
    m_drop   = 1'b0;
  endfunction

  function automatic int model_min();
    return (m_level != 0) ? MH : ML;
  endfunction

  function automatic bit model_busy();
    return (m_cyc < m_t + model_min());
  endfunction

  function automatic void model_step(input bit r, input bit f);
    bit both, opp, same, flip;
    both = r & f;
    opp  = !both && ((m_level != 0) ? f : r);
    same = !both && ((m_level != 0) ? r : f);
    flip = 1'b0;
    if (model_busy()) begin
      if (opp) m_queued = 1'b1;
      else if (same) m_queued = 1'b0;
      if (m_cyc == m_t + model_min() - 1) begin
        flip = m_queued;
        m_queued = 1'b0;
      end
    end else begin
      flip = opp;
    end
    if (flip) begin
      m_level = 1 - m_level;
      m_t     = m_cyc + 1;
      m_edges = m_edges + 1;
    end
    m_drop = both;
    m_cyc  = m_cyc + 1;
  endfunction

  task automatic tick(input bit r, input bit f);
    rise_req = r;
    fall_req = f;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      n_tests++;
      if (sig_out !== 1'b0 || busy !== 1'b0 || edge_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: sig=%b busy=%b edge=%0d want 0/0/0", i, sig_out, busy, edge_cnt);
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      n_tests++;
      if (sig_out !== 1'b0 || busy !== 1'b0 || pend !== 1'b0 || drop_err !== 1'b0 || edge_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_release cyc%0d: sig=%b busy=%b pend=%b drop=%b edge=%0d want all 0",
                 i, sig_out, busy, pend, drop_err, edge_cnt);
      end
    end
  endtask

  task automatic test_rise_then_late_fall();
    do_reset();
    tick(1'b1, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      n_tests++;
      if (sig_out !== 1'b1 || busy !== (k <= MH)) begin
        n_fail++;
        $display("FAIL late_fall N+%0d: sig=%b busy=%b want 1/%b", k, sig_out, busy, (k <= MH));
      end
      tick(1'b0, k == 10);
    end
    n_tests++;
    if (sig_out !== 1'b0 || edge_cnt !== 16'd2 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL late_fall N+11: sig=%b edge=%0d busy=%b want 0/2/1", sig_out, edge_cnt, busy);
    end
  endtask

  task automatic test_queued_fall();
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    for (int k = 2; k <= 4; k++) begin
      n_tests++;
      if (pend !== 1'b1 || sig_out !== 1'b1) begin
        n_fail++;
        $display("FAIL queued_fall N+%0d: pend=%b sig=%b want 1/1", k, pend, sig_out);
      end
      tick(1'b0, 1'b0);
    end
    for (int k = 5; k <= 7; k++) begin
      n_tests++;
      if (sig_out !== 1'b0 || busy !== 1'b1 || pend !== 1'b0 || edge_cnt !== 16'd2) begin
        n_fail++;
        $display("FAIL queued_fall_low N+%0d: sig=%b busy=%b pend=%b edge=%0d want 0/1/0/2",
                 k, sig_out, busy, pend, edge_cnt);
      end
      tick(1'b0, 1'b0);
    end
    n_tests++;
    if (busy !== 1'b0 || sig_out !== 1'b0) begin
      n_fail++;
      $display("FAIL queued_fall N+8: busy=%b sig=%b want 0/0", busy, sig_out);
    end
  endtask

  task automatic test_cancel();
    do_reset();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    n_tests++;
    if (pend !== 1'b0 || sig_out !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL cancel N+3: pend=%b sig=%b busy=%b want 0/1/1", pend, sig_out, busy);
    end
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    for (int k = 5; k <= 7; k++) begin
      n_tests++;
      if (sig_out !== 1'b1 || busy !== 1'b0 || edge_cnt !== 16'd1) begin
        n_fail++;
        $display("FAIL cancel N+%0d: sig=%b busy=%b edge=%0d want 1/0/1", k, sig_out, busy, edge_cnt);
      end
      tick(1'b0, 1'b0);
    end
  endtask

  task automatic test_both_req();
    do_reset();
    tick(1'b1, 1'b1);
    n_tests++;
    if (drop_err !== 1'b1 || sig_out !== 1'b0 || edge_cnt !== 16'd0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL both N+1: drop=%b sig=%b edge=%0d busy=%b want 1/0/0/0", drop_err, sig_out, edge_cnt, busy);
    end
    tick(1'b0, 1'b0);
    n_tests++;
    if (drop_err !== 1'b0 || sig_out !== 1'b0) begin
      n_fail++;
      $display("FAIL both N+2: drop=%b sig=%b want 0/0", drop_err, sig_out);
    end
  endtask

  task automatic test_wrap_and_abort();
    do_reset();
    for (int i = 0; i < 65535; i++) begin
      f_rise = (i % 2 == 0);
      f_fall = (i % 2 == 1);
      @(negedge clk);
    end
    n_tests++;
    if (f_edge !== 16'hFFFF || f_sig !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_preload: edge=%h sig=%b want ffff/1", f_edge, f_sig);
    end
    f_rise = 1'b0;
    f_fall = 1'b1;
    @(negedge clk);
    f_fall = 1'b0;
    n_tests++;
    if (f_edge !== 16'h0000 || f_sig !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap: edge=%h sig=%b want 0000/0", f_edge, f_sig);
    end
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
    n_tests++;
    if (pend !== 1'b1 || busy !== 1'b1 || sig_out !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_setup: pend=%b busy=%b sig=%b want 1/1/1", pend, busy, sig_out);
    end
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    n_tests++;
    if (sig_out !== 1'b0 || pend !== 1'b0 || busy !== 1'b0 || edge_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL abort: sig=%b pend=%b busy=%b edge=%0d want 0/0/0/0", sig_out, pend, busy, edge_cnt);
    end
  endtask

  task automatic test_random();
    bit r, f;
    int x;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      n_tests++;
      if (sig_out !== m_level[0] || busy !== model_busy() || pend !== m_queued ||
          drop_err !== m_drop || edge_cnt !== m_edges[15:0]) begin
        n_fail++;
        $display("FAIL random cyc%0d: sig=%b busy=%b pend=%b drop=%b edge=%0d want %b/%b/%b/%b/%0d",
                 i, sig_out, busy, pend, drop_err, edge_cnt,
                 m_level[0], model_busy(), m_queued, m_drop, m_edges[15:0]);
      end
      x = $urandom_range(0, 9);
      r = (x <= 2) || (x == 6);
      f = (x >= 3 && x <= 6);
      model_step(r, f);
      tick(r, f);
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    test_reset();
    test_rise_then_late_fall();
    test_queued_fall();
    test_cancel();
    test_both_req();
    test_random();
    test_wrap_and_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
